// File: rtl/input_buffer_fifo.sv
// input_buffer_fifo
//   First-word-fall-through FIFO that buffers N-lane vector beats (with
//   end-of-frame markers) while the downstream stage stalls. It reports
//   occupancy, detects overflow with a saturating drop count, and supports
//   a synchronous flush.
//
// Ports
//   clk_in          clock, all state on rising edge
//   rst_n_in        asynchronous active-low reset
//   valid_in        vector_in carries a valid beat
//   eof_in          end-of-frame marker (with or without valid_in)
//   vector_in       N lanes of WIDTH bits
//   flush_in        synchronous clear of contents and overflow status
//   ready_in        downstream accepts the head entry this cycle
//   valid_out       head entry holds a valid vector
//   eof_out         head entry carries eof
//   vector_out      head entry vector, zero when empty
//   occupancy_out   number of stored entries
//   full_out        occupancy == DEPTH
//   overflow_out    sticky, a push was dropped
//   drop_count_out  saturating count of dropped pushes
module input_buffer_fifo #(
  parameter int unsigned N     = 8,
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 8,
  parameter int unsigned CNT_W = 16
) (
  input  logic                            clk_in,
  input  logic                            rst_n_in,
  input  logic                            valid_in,
  input  logic                            eof_in,
  input  logic [N-1:0][WIDTH-1:0]         vector_in,
  input  logic                            flush_in,
  input  logic                            ready_in,
  output logic                            valid_out,
  output logic                            eof_out,
  output logic [N-1:0][WIDTH-1:0]         vector_out,
  output logic [$clog2(DEPTH+1)-1:0]      occupancy_out,
  output logic                            full_out,
  output logic                            overflow_out,
  output logic [CNT_W-1:0]                drop_count_out
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned OCC_W = $clog2(DEPTH + 1);

  typedef struct packed {
    logic                    valid;
    logic                    eof;
    logic [N-1:0][WIDTH-1:0] vec;
  } entry_t;

  entry_t             mem_q [DEPTH];
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [OCC_W-1:0]   occ_q, occ_d;
  logic               overflow_q, overflow_d;
  logic [CNT_W-1:0]   drop_cnt_q, drop_cnt_d;

  logic               empty;
  logic               full;
  logic               push_req;
  logic               pop;
  logic               push_ok;
  logic               drop;
  entry_t             head;

  // Push/pop decisions; a full FIFO still accepts a push when a pop frees a slot.
  always_comb begin
    empty    = (occ_q == '0);
    full     = (occ_q == OCC_W'(DEPTH));
    push_req = valid_in | eof_in;
    pop      = !empty && ready_in;
    push_ok  = push_req && (!full || pop);
    drop     = push_req && !push_ok;
  end

  // Next-state for pointers, occupancy and overflow status; flush overrides all.
  always_comb begin
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    occ_d      = occ_q;
    overflow_d = overflow_q;
    drop_cnt_d = drop_cnt_q;
    if (flush_in) begin
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      occ_d      = '0;
      overflow_d = 1'b0;
      drop_cnt_d = '0;
    end else begin
      if (push_ok) begin
        wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      if (push_ok && !pop) begin
        occ_d = occ_q + OCC_W'(1);
      end else if (pop && !push_ok) begin
        occ_d = occ_q - OCC_W'(1);
      end
      if (drop) begin
        overflow_d = 1'b1;
        if (drop_cnt_q != {CNT_W{1'b1}}) begin
          drop_cnt_d = drop_cnt_q + CNT_W'(1);
        end
      end
    end
  end

  // Control state registers.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      occ_q      <= '0;
      overflow_q <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      occ_q      <= occ_d;
      overflow_q <= overflow_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  // Storage array; contents are qualified by occupancy so no reset is needed.
  always_ff @(posedge clk_in) begin
    if (push_ok && !flush_in) begin
      mem_q[wr_ptr_q] <= '{valid: valid_in, eof: eof_in, vec: vector_in};
    end
  end

  // Head presentation, derived from registered state only.
  always_comb begin
    head           = mem_q[rd_ptr_q];
    valid_out      = !empty && head.valid;
    eof_out        = !empty && head.eof;
    vector_out     = empty ? '0 : head.vec;
    occupancy_out  = occ_q;
    full_out       = full;
    overflow_out   = overflow_q;
    drop_count_out = drop_cnt_q;
  end

endmodule
